seq_det_prog: RTL and testbench



---
 rtl/seq_det_prog_if.sv | 27 ++
 rtl/seq_det_prog.sv | 85 ++++++++
 tb/tb_seq_det_prog.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_prog_if.sv
// Serial bit-stream and configuration bundle for seq_det_prog.
// master drives stream and config, slave returns the match pulse and the count.
interface seq_det_prog_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8
);
    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    logic               x;
    logic               in_valid;
    logic               ovl_mode;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output x, in_valid, ovl_mode, cfg_load, cfg_pattern, cfg_len,
        input  z, match_cnt
    );

    modport slave (
        input  x, in_valid, ovl_mode, cfg_load, cfg_pattern, cfg_len,
        output z, match_cnt
    );
endinterface

// File: rtl/seq_det_prog.sv
// Programmable Mealy serial-pattern detector, overlapping or non-overlapping.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter.
module seq_det_prog #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0001_1001),
    parameter int unsigned        DEF_LEN     = 5,
    parameter int unsigned        CNT_W       = 8
) (
    input logic           clk,
    input logic           rst,
    seq_det_prog_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned FILL_W = $clog2(MAX_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN - 1);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-2:0] hist_q;
    logic [FILL_W-1:0]  fill_q;

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_load;
    logic               accept;
    logic               match;

    always_comb begin
        window = {hist_q, bus.x};
        mask   = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len_q));
        end
        accept = bus.in_valid && !bus.cfg_load && !rst;
        match  = accept && (int'(fill_q) >= int'(len_q) - 1) &&
                 (((window ^ pattern_q) & mask) == '0);

        len_load = bus.cfg_len;
        if (bus.cfg_len == '0) begin
            len_load = LEN_W'(1);
        end else if (int'(bus.cfg_len) > int'(MAX_LEN)) begin
            len_load = LEN_W'(MAX_LEN);
        end
    end

    assign bus.z = match;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            hist_q    <= '0;
            fill_q    <= '0;
        end else if (bus.cfg_load) begin
            pattern_q <= bus.cfg_pattern;
            len_q     <= len_load;
            hist_q    <= '0;
            fill_q    <= '0;
        end else if (bus.in_valid) begin
            hist_q <= window[MAX_LEN-2:0];
            // Non-overlap: forget history validity so the next match needs len fresh bits
            if (match && !bus.ovl_mode) begin
                fill_q <= '0;
            end else if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || bus.cfg_load) begin
            cnt_q <= '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_det_prog.sv
// Directed bench for seq_det_prog (MAX_LEN=8, CNT_W=2 to reach counter saturation).
module tb_seq_det_prog;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    seq_det_prog_if #(.MAX_LEN(8), .CNT_W(2)) bus ();

    seq_det_prog #(
        .MAX_LEN    (8),
        .DEF_PATTERN(8'b0001_1001),
        .DEF_LEN    (5),
        .CNT_W      (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [1:0] exp_cnt(input int unsigned n);
        if (!CNT_EN) return 2'd0;
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    // Drive one cycle of stream input at negedge; z sampled 1 ns later.
    task automatic step(input logic xb, input logic v, output logic zo);
        @(negedge clk);
        rst          = 1'b0;
        bus.cfg_load = 1'b0;
        bus.x        = xb;
        bus.in_valid = v;
        #1 zo = bus.z;
    endtask

    task automatic do_reset(output logic zo);
        @(negedge clk);
        rst          = 1'b1;
        bus.cfg_load = 1'b0;
        bus.x        = 1'b1;
        bus.in_valid = 1'b1;
        #1 zo = bus.z;
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len, output logic zo);
        @(negedge clk);
        rst             = 1'b0;
        bus.cfg_load    = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.x           = 1'b1;
        bus.in_valid    = 1'b1;
        #1 zo = bus.z;
    endtask

    task automatic idle();
        @(negedge clk);
        rst          = 1'b0;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic zo;
        do_reset(zo);
        checks++;
        if (zo !== 1'b0) begin
            errors++;
            $display("FAIL reset_z got %0b want 0", zo);
        end
        idle();
        checks++;
        if (bus.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", bus.match_cnt);
        end
    endtask

    task automatic test_overlap();
        logic       zo;
        logic [8:0] s = 9'b100110011;
        logic [8:0] e = 9'b100010000;
        bus.ovl_mode = 1'b1;
        do_reset(zo);
        for (int i = 0; i < 9; i++) begin
            step(s[i], 1'b1, zo);
            checks++;
            if (zo !== e[i]) begin
                errors++;
                $display("FAIL overlap_z idx %0d got %0b want %0b", i, zo, e[i]);
            end
        end
        idle();
        checks++;
        if (bus.match_cnt !== exp_cnt(2)) begin
            errors++;
            $display("FAIL overlap_cnt got %0d want %0d", bus.match_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_non_overlap();
        logic        zo;
        logic [12:0] s = 13'b1001100110011;
        logic [12:0] e = 13'b1000000010000;
        bus.ovl_mode = 1'b0;
        do_reset(zo);
        for (int i = 0; i < 13; i++) begin
            step(s[i], 1'b1, zo);
            checks++;
            if (zo !== e[i]) begin
                errors++;
                $display("FAIL nonovl_z idx %0d got %0b want %0b", i, zo, e[i]);
            end
        end
        idle();
        checks++;
        if (bus.match_cnt !== exp_cnt(2)) begin
            errors++;
            $display("FAIL nonovl_cnt got %0d want %0d", bus.match_cnt, exp_cnt(2));
        end
    endtask

    task automatic test_len3();
        logic       zo;
        logic [4:0] e_ovl = 5'b11100;
        logic [5:0] e_non = 6'b100100;
        bus.ovl_mode = 1'b1;
        do_load(8'b0000_0111, 4'd3, zo);
        checks++;
        if (zo !== 1'b0) begin
            errors++;
            $display("FAIL load_z got %0b want 0", zo);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, zo);
            checks++;
            if (zo !== e_ovl[i]) begin
                errors++;
                $display("FAIL len3_ovl_z idx %0d got %0b want %0b", i, zo, e_ovl[i]);
            end
        end
        idle();
        checks++;
        if (bus.match_cnt !== exp_cnt(3)) begin
            errors++;
            $display("FAIL len3_ovl_cnt got %0d want %0d", bus.match_cnt, exp_cnt(3));
        end
        bus.ovl_mode = 1'b0;
        do_load(8'b0000_0111, 4'd3, zo);
        idle();
        checks++;
        if (bus.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL load_clr_cnt got %0d want 0", bus.match_cnt);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, zo);
            checks++;
            if (zo !== e_non[i]) begin
                errors++;
                $display("FAIL len3_non_z idx %0d got %0b want %0b", i, zo, e_non[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic       zo;
        logic [3:0] s = 4'b0011;
        bus.ovl_mode = 1'b1;
        do_reset(zo);
        for (int i = 0; i < 4; i++) begin
            step(s[i], 1'b1, zo);
            checks++;
            if (zo !== 1'b0) begin
                errors++;
                $display("FAIL gap_pre_z idx %0d got %0b want 0", i, zo);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, zo);
            checks++;
            if (zo !== 1'b0) begin
                errors++;
                $display("FAIL gap_idle_z cyc %0d got %0b want 0", i, zo);
            end
        end
        step(1'b1, 1'b1, zo);
        checks++;
        if (zo !== 1'b1) begin
            errors++;
            $display("FAIL gap_final_z got %0b want 1", zo);
        end
    endtask

    task automatic test_reset_mid();
        logic       zo;
        logic [2:0] pre = 3'b011;
        logic [6:0] s   = 7'b1001110;
        logic [6:0] e   = 7'b1000000;
        bus.ovl_mode = 1'b1;
        do_reset(zo);
        for (int i = 0; i < 3; i++) begin
            step(pre[i], 1'b1, zo);
        end
        do_reset(zo);
        checks++;
        if (zo !== 1'b0) begin
            errors++;
            $display("FAIL midrst_z got %0b want 0", zo);
        end
        for (int i = 0; i < 7; i++) begin
            step(s[i], 1'b1, zo);
            checks++;
            if (zo !== e[i]) begin
                errors++;
                $display("FAIL midrst_post_z idx %0d got %0b want %0b", i, zo, e[i]);
            end
        end
    endtask

    task automatic test_len1_clamp();
        logic       zo;
        logic [7:0] a5 = 8'hA5;
        bus.ovl_mode = 1'b0;
        do_load(8'b0000_0001, 4'd1, zo);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, zo);
            checks++;
            if (zo !== 1'b1) begin
                errors++;
                $display("FAIL len1_z idx %0d got %0b want 1", i, zo);
            end
        end
        step(1'b0, 1'b1, zo);
        checks++;
        if (zo !== 1'b0) begin
            errors++;
            $display("FAIL len1_zero_z got %0b want 0", zo);
        end
        idle();
        checks++;
        if (bus.match_cnt !== exp_cnt(6)) begin
            errors++;
            $display("FAIL len1_sat_cnt got %0d want %0d", bus.match_cnt, exp_cnt(6));
        end
        // cfg_len=0 must behave as length 1
        do_load(8'b0000_0000, 4'd0, zo);
        idle();
        checks++;
        if (bus.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL len1_load_cnt got %0d want 0", bus.match_cnt);
        end
        step(1'b0, 1'b1, zo);
        checks++;
        if (zo !== 1'b1) begin
            errors++;
            $display("FAIL clamp0_hit got %0b want 1", zo);
        end
        step(1'b1, 1'b1, zo);
        checks++;
        if (zo !== 1'b0) begin
            errors++;
            $display("FAIL clamp0_miss got %0b want 0", zo);
        end
        // cfg_len=15 must clamp to 8
        do_load(8'hA5, 4'd15, zo);
        for (int i = 7; i >= 0; i--) begin
            step(a5[i], 1'b1, zo);
            checks++;
            if (zo !== (i == 0)) begin
                errors++;
                $display("FAIL clamp8_z bit %0d got %0b want %0b", i, zo, (i == 0));
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.x           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.ovl_mode    = 1'b1;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_len3();
        test_gap();
        test_reset_mid();
        test_len1_clamp();
        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
